// File: rtl/dog_sprite_render.sv
// Dog sprite pixel stage: latches frame/position once per video frame,
// fetches the sprite from an external synchronous ROM and muxes the
// colour-keyed sprite over the background with a fixed 3-cycle latency.
module dog_sprite_render #(
  parameter int          SPR_W     = 32,
  parameter int          SPR_H     = 32,
  parameter int          FRAMES    = 5,
  parameter int          ADDR_W    = 13,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [2:0]        ActionSel,
  input  logic [9:0]        DogPos_x,
  input  logic [8:0]        DogPos_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out
);

  // Control/sync delay line: index 0 = after stage 1, index 1 = after stage 2.
  localparam int STAGES = 2;

  logic [2:0]        frame_q;
  logic [9:0]        x_q;
  logic [8:0]        y_q;
  logic              latch_trig;
  logic [10:0]       h_e, v_e, x_e, y_e, dx, dy;
  logic              inside_c;
  logic [ADDR_W-1:0] addr_c;
  logic [STAGES-1:0] ins_pipe, von_pipe, hs_pipe, vs_pipe;

  // First blanking line, column 0: safe point to swap frame parameters.
  assign latch_trig = (vcnt == 10'(V_ACTIVE)) && (hcnt == 10'd0);

  // Frame register: sprite parameters frozen for the whole visible frame.
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      frame_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (latch_trig) begin
      frame_q <= (32'(ActionSel) >= FRAMES) ? 3'd0 : ActionSel;
      x_q     <= DogPos_x;
      y_q     <= DogPos_y;
    end
  end

  // Stage 1 hit test and address; 11-bit sums keep x+SPR_W from wrapping,
  // so a sprite near the right/bottom edge is clipped rather than wrapped.
  always_comb begin
    h_e      = {1'b0, hcnt};
    v_e      = {1'b0, vcnt};
    x_e      = {1'b0, x_q};
    y_e      = {2'b0, y_q};
    dx       = h_e - x_e;
    dy       = v_e - y_e;
    inside_c = video_on &&
               (h_e >= x_e) && (h_e < x_e + 11'(SPR_W)) &&
               (v_e >= y_e) && (v_e < y_e + 11'(SPR_H));
    addr_c   = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H) +
               ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
  end

  // Stages 1-2: ROM address register plus control/sync shift registers.
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      rom_addr <= '0;
      ins_pipe <= '0;
      von_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else begin
      if (inside_c) rom_addr <= addr_c;
      ins_pipe <= {ins_pipe[0], inside_c};
      von_pipe <= {von_pipe[0], video_on};
      hs_pipe  <= {hs_pipe[0], hsync_in};
      vs_pipe  <= {vs_pipe[0], vsync_in};
    end
  end

  // Stage 3: blanking, colour-key transparency and sync realignment.
  always_ff @(posedge pixel_clk) begin
    if (!reset) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      if (!von_pipe[STAGES-1])
        rgb <= 12'h000;
      else if (ins_pipe[STAGES-1] && (rom_data != KEY_COLOR))
        rgb <= rom_data;
      else
        rgb <= BG_COLOR;
      hsync_out <= hs_pipe[STAGES-1];
      vsync_out <= vs_pipe[STAGES-1];
    end
  end

endmodule

// File: tb/tb_dog_sprite_render.sv
// Directed bench for dog_sprite_render: vector table replayed through the
// 3-cycle pipeline, plus hand-written reset and frame-latch sequences.
module tb_dog_sprite_render;

  logic        pixel_clk;
  logic        reset;
  logic [9:0]  hcnt, vcnt;
  logic        video_on, hsync_in, vsync_in;
  logic [2:0]  ActionSel;
  logic [9:0]  DogPos_x;
  logic [8:0]  DogPos_y;
  logic [12:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int n_chk  = 0;
  int n_fail = 0;

  dog_sprite_render dut (
    .pixel_clk(pixel_clk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ActionSel(ActionSel), .DogPos_x(DogPos_x), .DogPos_y(DogPos_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // Sprite ROM: data = address, except the key colour at pixel (105,310) of frame 2.
  always @(posedge pixel_clk)
    rom_data <= (rom_addr == 13'd2373) ? 12'hF0F : rom_addr[11:0];

  typedef struct {
    int h; int v; bit hs; bit vs; int act;
    bit ca; int addr; int rgb;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  task automatic add(input int h, input int v, input bit hs, input bit vs,
                     input int act, input bit ca, input int addr, input int rgbv);
    vt[nv] = '{h, v, hs, vs, act, ca, addr, rgbv};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input bit hs, input bit vs);
    hcnt     = 10'(h);
    vcnt     = 10'(v);
    video_on = (h < 640) && (v < 480);
    hsync_in = hs;
    vsync_in = vs;
  endtask

  // Replay vt[lo..hi], one per cycle; rom_addr checked 1 cycle later, rgb/syncs 3 later.
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi + 3; i++) begin
      @(negedge pixel_clk);
      if (i - 1 >= lo && i - 1 <= hi && vt[i-1].ca)
        chk($sformatf("addr[%0d]", i - 1), 32'(rom_addr), 32'(vt[i-1].addr));
      if (i - 3 >= lo && i - 3 <= hi) begin
        chk($sformatf("rgb[%0d]", i - 3), 32'(rgb), 32'(vt[i-3].rgb));
        chk($sformatf("hs[%0d]", i - 3), 32'(hsync_out), 32'(vt[i-3].hs));
        chk($sformatf("vs[%0d]", i - 3), 32'(vsync_out), 32'(vt[i-3].vs));
      end
      if (i <= hi) begin
        drive(vt[i].h, vt[i].v, vt[i].hs, vt[i].vs);
        ActionSel = 3'(vt[i].act);
      end else begin
        drive(700, 500, 1'b1, 1'b1);
      end
      @(posedge pixel_clk);
    end
  endtask

  // One trigger cycle, then scramble the position/frame inputs.
  task automatic latch(input int a, input int x, input int y);
    @(negedge pixel_clk);
    drive(0, 480, 1'b1, 1'b1);
    ActionSel = 3'(a);
    DogPos_x  = 10'(x);
    DogPos_y  = 9'(y);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    drive(700, 500, 1'b1, 1'b1);
    ActionSel = 3'd7;
    DogPos_x  = 10'd333;
    DogPos_y  = 9'd222;
    @(posedge pixel_clk);
  endtask

  int a0, a1, b0, b1, c0, c1, c2, d0, d1, e0, e1;

  initial begin
    // A: after reset, frame 0 at (0,0)
    a0 = nv;
    add(5, 5, 0, 1, 4, 1, 165, 12'h0A5);
    add(6, 5, 1, 0, 4, 1, 166, 12'h0A6);
    a1 = nv - 1;
    // B: frame 2 at (100,300); ActionSel input scrambled to 7
    b0 = nv;
    add(100, 300, 1, 1, 7, 1, 2048, 12'h800);
    add(131, 331, 1, 1, 7, 1, 3071, 12'hBFF);
    add(132, 331, 1, 1, 7, 1, 3071, 12'h000);
    add( 99, 300, 1, 1, 7, 1, 3071, 12'h000);
    add(105, 310, 0, 1, 7, 1, 2373, 12'h000);
    add(104, 310, 1, 1, 7, 1, 2372, 12'h944);
    add(106, 310, 1, 0, 7, 1, 2374, 12'h946);
    add(105, 309, 1, 1, 7, 1, 2341, 12'h925);
    add(100, 332, 1, 1, 7, 1, 2341, 12'h000);
    add(100, 299, 1, 1, 7, 1, 2341, 12'h000);
    add(700, 300, 0, 1, 7, 0, 0,    12'h000);
    b1 = nv - 1;
    // C: frame 1 at (10,190); ActionSel moves to 3 mid-frame
    c0 = nv;
    add(10, 195, 1, 1, 1, 1, 1184, 12'h4A0);
    add(12, 200, 1, 1, 3, 1, 1346, 12'h542);
    add(12, 210, 1, 1, 3, 1, 1666, 12'h682);
    c1 = nv - 1;
    c2 = nv;
    add(12, 200, 1, 1, 0, 1, 3394, 12'hD42);
    // D: x=620, clipped by video_on, no wrap to left edge
    d0 = nv;
    add(620, 101, 1, 1, 2, 1, 32, 12'h020);
    add(639, 101, 1, 1, 2, 1, 51, 12'h033);
    add(640, 101, 0, 1, 2, 1, 51, 12'h000);
    add(651, 101, 1, 1, 2, 1, 51, 12'h000);
    add(  0, 101, 1, 1, 2, 1, 51, 12'h000);
    add( 11, 101, 1, 0, 2, 1, 51, 12'h000);
    d1 = nv - 1;
    // E: ActionSel=6 latched as frame 0 at (200,50)
    e0 = nv;
    add(200, 50, 1, 1, 1, 1, 0,    12'h000);
    add(201, 50, 1, 1, 1, 1, 1,    12'h001);
    add(231, 81, 1, 1, 1, 1, 1023, 12'h3FF);
    e1 = nv - 1;

    // Reset held with active inputs inside the default sprite
    reset = 1'b0;
    drive(5, 5, 1'b0, 1'b0);
    ActionSel = 3'd2;
    DogPos_x  = 10'd100;
    DogPos_y  = 9'd300;
    repeat (4) begin
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_hs", 32'(hsync_out), 32'h1);
      chk("rst_vs", 32'(vsync_out), 32'h1);
      chk("rst_addr", 32'(rom_addr), 32'h0);
    end
    reset = 1'b1;
    run(a0, a1);

    latch(2, 100, 300);
    run(b0, b1);

    latch(1, 10, 190);
    run(c0, c1);
    latch(3, 10, 190);
    run(c2, c2);

    latch(0, 620, 100);
    run(d0, d1);

    latch(6, 200, 50);
    run(e0, e1);

    // Mid-line reset: blank on the same edge, then refill from x=y=0
    for (int k = 0; k < 3; k++) begin
      @(negedge pixel_clk);
      drive(210 + k, 50, (k == 0) ? 1'b0 : 1'b1, 1'b1);
      @(posedge pixel_clk);
    end
    @(negedge pixel_clk);
    chk("pre_rst_rgb", 32'(rgb), 32'h00A);
    chk("pre_rst_hs", 32'(hsync_out), 32'h0);
    reset = 1'b0;
    drive(213, 50, 1'b0, 1'b0);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("mid_rst_rgb", 32'(rgb), 32'h0);
    chk("mid_rst_hs", 32'(hsync_out), 32'h1);
    chk("mid_rst_addr", 32'(rom_addr), 32'h0);
    reset = 1'b1;
    drive(3, 2, 1'b1, 1'b0);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("refill_addr", 32'(rom_addr), 32'd67);
    drive(700, 500, 1'b1, 1'b1);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("refill_rgb", 32'(rgb), 32'h043);
    chk("refill_vs", 32'(vsync_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
